xor_frame_checksum: RTL and testbench
=====================================

# xor_frame_checksum

Streaming XOR checksum engine: accumulates the bitwise XOR of every word in a frame and presents the result, the word count and a length-violation flag on a valid/ready output port. It extends the team's two-input XOR gate to WIDTH-bit words, arbitrary-length frames and backpressured handshakes. It sits between a word source (UART/switch capture) and a consumer (display/compare logic) on one clock domain.

## Interface

Parameters:
- WIDTH, 8, data word width in bits (≥1)
- MAX_LEN, 16, maximum words per frame (≥1); a frame reaching MAX_LEN without in_last is force-closed
- CNT_W, derived localparam = clog2(MAX_LEN+1), width of the length field

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  source has a word on in_data
- in_data  input  WIDTH  input word
- in_last  input  1  word is the final word of the frame
- in_ready  output  1  block accepts a word this cycle
- out_valid  output  1  checksum result available
- out_data  output  WIDTH  XOR of all accepted words in the frame
- out_len  output  CNT_W  number of words accepted in the frame (1..MAX_LEN)
- out_err  output  1  frame was force-closed at MAX_LEN without in_last
- out_ready  input  1  consumer takes the result this cycle

## Operation

- States: ACC (accumulating), HOLD (result presented).
- Registers: acc[WIDTH], cnt[CNT_W], result registers out_data/out_len/out_err, out_valid.
- in_ready = (state == ACC), decoded from the state register only (no combinational path from any input).
- Beat accepted when in_valid && in_ready.
- ACC, beat accepted, not closing: acc <= acc ^ in_data; cnt <= cnt + 1.
- ACC, beat accepted, closing (in_last==1 or cnt+1 == MAX_LEN): out_data <= acc ^ in_data; out_len <= cnt + 1; out_err <= ~in_last; out_valid <= 1; acc <= 0; cnt <= 0; state <= HOLD.
- in_last with cnt+1 == MAX_LEN: normal close, out_err = 0.
- HOLD: in_ready = 0; out_data/out_len/out_err held stable while out_valid=1. On out_ready: out_valid <= 0, state <= ACC.
- out_ready while out_valid=0: ignored.
- in_valid while in_ready=0: ignored, no state change; source must hold its word.
- Empty frames do not exist; a frame is at least one word.
- XOR is bitwise, no carries; cnt never exceeds MAX_LEN.

## Timing

- Reset (rst_n low, asynchronous): state=ACC, acc=0, cnt=0, out_valid=0, out_data=0, out_len=0, out_err=0; in_ready=1 as soon as rst_n is high.
- Reset asserted mid-frame or in HOLD: partial frame and pending result discarded immediately, with no output beat.
- Latency: out_valid rises on the clock edge that accepts the closing beat and is visible in the next cycle.
- HOLD lasts ≥1 cycle. With out_ready tied high, HOLD lasts exactly 1 cycle, so an N-word frame occupies N+1 cycles.
- First word of the next frame is accepted no earlier than the cycle after the out_valid && out_ready handshake.
- Stalls (in_valid low mid-frame) hold acc/cnt indefinitely; there is no timeout.

## Test plan

- Reset: rst_n=0 asynchronously mid-frame after 2 words -> out_valid=0, out_data=0, out_len=0, out_err=0, in_ready=1 after release; the next frame {0x0F} gives out_data=0x0F, out_len=1.
- Basic frame (WIDTH=8): words 0x12,0x34,0x56 (last on 0x56), out_ready=1 -> out_data=0x70, out_len=3, out_err=0; out_valid high for exactly 1 cycle, one cycle after the last beat.
- Backpressure: same frame, out_ready=0 for 5 cycles -> out_valid/out_data stay 0x70 and in_ready stays 0 for all 5 cycles; a 0xFF offered during HOLD is not consumed; after out_ready=1, 0xFF starts the next frame.
- Single-word and self-cancel: frame {0xA5} -> 0xA5, len 1; frame {0xA5,0xA5} -> 0x00, len 2.
- Force-close (MAX_LEN=16): 17 words of 0x01 with no in_last -> first result 0x00, out_len=16, out_err=1; the 17th word starts a new frame. A separate 16-word frame with in_last on word 16 -> out_err=0.
- Input gaps: in_valid toggled 1,0,0,1,1 with words 0x80,0x40,0x01(last) -> out_data=0xC1, out_len=3; random-stall regression matches a software XOR model.

Source files
------------

// File: rtl/xor_frame_checksum.sv
// xor_frame_checksum: streaming XOR checksum over valid/ready framed words.
// A frame closes on in_last or after MAX_LEN words; the result is held until out_ready.
module xor_frame_checksum #(
    parameter int  WIDTH   = 8,
    parameter int  MAX_LEN = 16,
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_len,
    output logic             out_err,
    input  logic             out_ready
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(MAX_LEN);

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0] out_len_q,   out_len_d;
    logic             out_err_q,   out_err_d;
    logic             out_valid_q, out_valid_d;

    logic             beat;
    logic             closing;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] acc_next;

    // in_ready depends on the state register alone, so no input reaches it combinationally.
    assign in_ready = (state_q == ST_ACC);
    assign beat     = in_valid && in_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign acc_next = acc_q ^ in_data;
    assign closing  = in_last || (cnt_inc == LEN_MAX);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_len_d   = out_len_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_ACC: begin
                if (beat) begin
                    if (closing) begin
                        out_data_d  = acc_next;
                        out_len_d   = cnt_inc;
                        out_err_d   = ~in_last;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_len_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_len_q   <= out_len_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_len   = out_len_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Self-checking bench for xor_frame_checksum: vector table, hand-written corner
// sequences, and a randomized stream compared against a frame-splitting model.
module tb_xor_frame_checksum;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_len;
    logic             out_err;
    logic             out_ready;

    int n_vec;
    int n_err;

    xor_frame_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_len   (out_len),
        .out_err   (out_err),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           n;
        bit           last_end;
        logic [127:0] words;     // word j at bits [j*8 +: 8]
        logic [7:0]   e_data;
        int           e_len;
        bit           e_err;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        int         len;
        bit         err;
    } res_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one word and returns just after the edge that accepted it.
    task automatic send_word(input logic [7:0] d, input logic last);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for word 0x%0h", d);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(output res_t r);
        int waited;
        out_ready = 1'b1;
        waited    = 0;
        while (!out_valid && waited < 50) begin
            step();
            waited++;
        end
        check("result_valid", 32'(out_valid), 32'd1);
        r.data = out_data;
        r.len  = int'(out_len);
        r.err  = out_err;
        step();
    endtask

    task automatic check_res(input string tag, input res_t r, input logic [7:0] d, input int len, input bit err);
        check({tag, "_data"}, 32'(r.data), 32'(d));
        check({tag, "_len"},  32'(r.len),  32'(len));
        check({tag, "_err"},  32'(r.err),  32'(err));
    endtask

    // Reference: split a flat word stream into frames by the closing rules.
    task automatic model_frames(input logic [7:0] w[$], input bit l[$], output res_t q[$]);
        logic [7:0] x;
        int         cnt;
        res_t       r;
        q   = {};
        x   = 8'h00;
        cnt = 0;
        foreach (w[i]) begin
            x ^= w[i];
            cnt++;
            if (l[i] || cnt == MAX_LEN) begin
                r.data = x;
                r.len  = cnt;
                r.err  = !l[i];
                q.push_back(r);
                x   = 8'h00;
                cnt = 0;
            end
        end
    endtask

    initial begin
        res_t         r;
        logic [127:0] wv;
        logic [7:0]   rw[$];
        bit           rl[$];
        res_t         exp_q[$];
        int           drv_done;

        n_vec     = 0;
        n_err     = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;

        vecs[0] = '{3,  1'b1, 128'({8'h56, 8'h34, 8'h12}),          8'h70, 3,  1'b0};
        vecs[1] = '{1,  1'b1, 128'(8'hA5),                           8'hA5, 1,  1'b0};
        vecs[2] = '{2,  1'b1, 128'({8'hA5, 8'hA5}),                  8'h00, 2,  1'b0};
        vecs[3] = '{16, 1'b1, {16{8'h01}},                           8'h00, 16, 1'b0};
        vecs[4] = '{16, 1'b0, {16{8'h01}},                           8'h00, 16, 1'b1};
        vecs[5] = '{4,  1'b1, 128'({8'h08, 8'h04, 8'h02, 8'h01}),   8'h0F, 4,  1'b0};
        vecs[6] = '{15, 1'b1, 128'({15{8'h01}}),                     8'h01, 15, 1'b0};

        // Power-on reset values.
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_len",   32'(out_len),   32'd0);
        check("rst_out_err",   32'(out_err),   32'd0);
        step();
        step();
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic frame with exact one-cycle output pulse.
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b0);
        check("lat_before_last", 32'(out_valid), 32'd0);
        send_word(8'h56, 1'b1);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data",  32'(out_data),  32'h70);
        check("lat_ready", 32'(in_ready),  32'd0);
        step();
        check("pulse_one_cycle", 32'(out_valid), 32'd0);

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            wv = vecs[i].words;
            for (int j = 0; j < vecs[i].n; j++)
                send_word(wv[j*8 +: 8], vecs[i].last_end && (j == vecs[i].n - 1));
            get_result(r);
            check_res($sformatf("vec%0d", i), r, vecs[i].e_data, vecs[i].e_len, vecs[i].e_err);
        end

        // Force-close: the 17th word opens a new frame.
        for (int j = 0; j < 16; j++) send_word(8'h01, 1'b0);
        get_result(r);
        check_res("fc_first", r, 8'h00, 16, 1'b1);
        send_word(8'h01, 1'b0);
        send_word(8'h02, 1'b1);
        get_result(r);
        check_res("fc_next", r, 8'h03, 2, 1'b0);

        // Backpressure: result held and 0xFF refused for 5 cycles.
        out_ready = 1'b0;
        send_word(8'h12, 1'b0);
        send_word(8'h34, 1'b0);
        send_word(8'h56, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_data%0d", k),  32'(out_data),  32'h70);
            check($sformatf("bp_ready%0d", k), 32'(in_ready),  32'd0);
            step();
        end
        out_ready = 1'b1;
        send_word(8'hFF, 1'b1);
        get_result(r);
        check_res("bp_next", r, 8'hFF, 1, 1'b0);

        // Input gaps: in_valid 1,0,0,1,1.
        send_word(8'h80, 1'b0);
        step();
        step();
        send_word(8'h40, 1'b0);
        send_word(8'h01, 1'b1);
        get_result(r);
        check_res("gap", r, 8'hC1, 3, 1'b0);

        // Asynchronous reset mid-frame after 2 words.
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'd0);
        check("mid_rst_len",   32'(out_len),   32'd0);
        check("mid_rst_err",   32'(out_err),   32'd0);
        step();
        rst_n = 1'b1;
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        send_word(8'h0F, 1'b1);
        get_result(r);
        check_res("post_rst", r, 8'h0F, 1, 1'b0);

        // Reset while a result is pending discards it.
        out_ready = 1'b0;
        send_word(8'h33, 1'b1);
        check("hold_pre_rst", 32'(out_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("hold_rst_valid", 32'(out_valid), 32'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("hold_rst_no_beat", 32'(out_valid), 32'd0);

        // Randomized stream with gaps and random backpressure.
        rw = {};
        rl = {};
        for (int k = 0; k < 400; k++) begin
            rw.push_back(8'($urandom));
            rl.push_back(($urandom_range(0, 5) == 0) || (k == 399));
        end
        model_frames(rw, rl, exp_q);
        drv_done = 0;
        fork
            begin
                foreach (rw[k]) begin
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
                    send_word(rw[k], rl[k]);
                end
                drv_done = 1;
            end
            begin
                int idx;
                int cyc;
                idx = 0;
                cyc = 0;
                while (idx < exp_q.size() && cyc < 20000) begin
                    step();
                    cyc++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        check_res($sformatf("rnd%0d", idx), '{out_data, int'(out_len), out_err},
                                  exp_q[idx].data, exp_q[idx].len, exp_q[idx].err);
                        idx++;
                    end
                end
                if (idx < exp_q.size()) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rnd_timeout: got %0d results, expected %0d", idx, exp_q.size());
                end
            end
        join
        check("rnd_driver_done", 32'(drv_done), 32'd1);
        out_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
